// File: rtl/prog_loader.sv
// Byte-stream program loader: takes a word-count header and little-endian instruction
// bytes, writes 32-bit words to instruction memory from address 0, and holds the core in reset until the load completes.
module prog_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int         CNT_W   = ADDR_W + 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    BYTES,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [CNT_W-1:0]  count;
  logic [23:0]       asm_q;     // lanes 0..2; lane 3 goes straight into the write word
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic hdr_bad;
  logic last_word;

  assign hdr_bad   = (byte_data == 8'd0) || (byte_data > DEPTH_B);
  assign last_word = ({1'b0, word_idx} == (count - CNT_W'(1)));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output and next-state gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_rst_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = HEADER;
      end
      HEADER: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_d = hdr_bad ? ERROR : BYTES;
      end
      BYTES: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && (byte_idx == 2'd3)) state_d = WRITE;
      end
      WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
        state_d = last_word ? DONE : BYTES;
      end
      DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
        if (start) state_d = HEADER;
      end
      ERROR: begin
        error = 1'b1;
        if (start) state_d = HEADER;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath; write address/data are registered so they hold between strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_idx <= '0;
      word_idx <= '0;
      count    <= '0;
      asm_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        HEADER: begin
          if (byte_valid && !hdr_bad) begin
            count    <= CNT_W'(byte_data);
            byte_idx <= '0;
            word_idx <= '0;
          end
        end
        BYTES: begin
          if (byte_valid) begin
            if (byte_idx == 2'd3) begin
              addr_q  <= word_idx;
              wdata_q <= {byte_data, asm_q};
            end else begin
              asm_q[{byte_idx, 3'b000} +: 8] <= byte_data;
              byte_idx                       <= byte_idx + 2'd1;
            end
          end
        end
        WRITE: begin
          if (!last_word) begin
            word_idx <= word_idx + ADDR_W'(1);
            byte_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: single word, gapped multi-word, illegal headers,
// full depth, and abort/reload, with immediate-assertion checks.
module tb_prog_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              error;

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Passive capture of what the DUT does at each edge.
  logic [31:0] mem [DEPTH];
  int          addr_log [256];
  int          cyc       = 0;
  int          wr_count  = 0;
  int          wr_cyc    = 0;
  int          xfer_cnt  = 0;
  int          bad_ready = 0;

  always @(posedge clk) begin
    cyc++;
    if (byte_valid && byte_ready) xfer_cnt++;
    if (imem_we) begin
      mem[imem_addr]     = imem_wdata;
      addr_log[wr_count] = int'(imem_addr);
      wr_count++;
      wr_cyc = cyc;
      if (byte_ready) bad_ready++;
    end
  end

  int total = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, output int xcyc);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_ready timeout", 32'd1, 32'd0);
    xcyc = cyc + 1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    int xc;
    for (int k = 0; k < 4; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(w[8*k +: 8], xc);
    end
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done;
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait done", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] full_word(input int i);
    return {8'(i), 8'hA5, 8'(i * 7), 8'h3C};
  endfunction

  int          hdr_cyc;
  int          base;
  int          errs;
  logic [31:0] words3 [3];

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h55;

    // Reset with byte_valid asserted
    repeat (2) @(negedge clk);
    check("reset outputs", {byte_ready, imem_we, cpu_rst_n, busy, done, error}, 32'd0);
    check("reset addr", 32'(imem_addr), 32'd0);
    check("reset wdata", imem_wdata, 32'd0);
    check("reset no handshake", 32'(xfer_cnt), 32'd0);
    byte_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    check("idle cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("idle ready/busy", {byte_ready, busy}, 32'd0);

    // Single word 0x00500113
    pulse_start();
    check("header busy", {busy, byte_ready, cpu_rst_n}, 32'b110);
    base = wr_count;
    send_byte(8'h01, hdr_cyc);
    send_word(32'h0050_0113, 1'b0);
    check("single we", 32'(imem_we), 32'd1);
    check("single addr", 32'(imem_addr), 32'd0);
    check("single wdata", imem_wdata, 32'h0050_0113);
    check("single ready low", 32'(byte_ready), 32'd0);
    @(negedge clk);
    check("single latency", 32'(wr_cyc - hdr_cyc), 32'd5);
    check("single done", {done, cpu_rst_n, busy}, 32'b110);
    repeat (3) @(negedge clk);
    check("single one write", 32'(wr_count - base), 32'd1);

    // Three words with random gaps
    words3[0] = 32'h0000_0000;
    words3[1] = 32'h0041_9193;
    words3[2] = 32'h0021_0233;
    base = wr_count;
    xfer_cnt = 0;
    pulse_start();
    send_byte(8'h03, hdr_cyc);
    for (int i = 0; i < 3; i++) send_word(words3[i], 1'b1);
    wait_done();
    check("three count", 32'(wr_count - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("three addr %0d", i), 32'(addr_log[base + i]), 32'(i));
      check($sformatf("three data %0d", i), mem[i], words3[i]);
    end
    check("three bytes", 32'(xfer_cnt), 32'd13);
    check("three ready in write", 32'(bad_ready), 32'd0);

    // Illegal headers
    base = wr_count;
    pulse_start();
    send_byte(8'h00, hdr_cyc);
    check("hdr0 flags", {error, byte_ready, busy, done, cpu_rst_n}, 32'b10000);
    pulse_start();
    check("error clears", 32'(error), 32'd0);
    send_byte(8'h21, hdr_cyc);
    check("hdr21 error", 32'(error), 32'd1);
    repeat (2) @(negedge clk);
    check("illegal no write", 32'(wr_count - base), 32'd0);
    pulse_start();
    send_byte(8'h01, hdr_cyc);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_done();
    check("recover error", 32'(error), 32'd0);
    check("recover data", mem[0], 32'hDEAD_BEEF);

    // Full depth
    base = wr_count;
    pulse_start();
    send_byte(8'h20, hdr_cyc);
    for (int i = 0; i < DEPTH; i++) send_word(full_word(i), 1'b0);
    wait_done();
    repeat (5) @(negedge clk);
    check("full count", 32'(wr_count - base), 32'd32);
    check("full last addr", 32'(addr_log[base + 31]), 32'd31);
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_log[base + i] != i) errs++;
      if (mem[i] !== full_word(i)) errs++;
    end
    check("full contents", 32'(errs), 32'd0);

    // Abort mid word 1, then reload
    base = wr_count;
    pulse_start();
    send_byte(8'h02, hdr_cyc);
    send_word(32'h4433_2211, 1'b0);
    send_byte(8'h55, hdr_cyc);
    send_byte(8'h66, hdr_cyc);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("abort writes", 32'(wr_count - base), 32'd1);
    check("abort idle", {busy, byte_ready, cpu_rst_n, done}, 32'd0);
    check("abort word0", mem[0], 32'h4433_2211);
    check("abort word1 kept", mem[1], full_word(1));
    pulse_start();
    send_byte(8'h01, hdr_cyc);
    send_word(32'h0BAD_F00D, 1'b0);
    wait_done();
    check("reload released", 32'(cpu_rst_n), 32'd1);
    pulse_start();
    check("restart holds core", {cpu_rst_n, busy, done}, 32'b010);
    send_byte(8'h01, hdr_cyc);
    send_word(32'hCAFE_BABE, 1'b0);
    wait_done();
    check("reload overwrite", mem[0], 32'hCAFE_BABE);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
